// File: rtl/control_seq_pkg.sv
// Shared types and constants for the sequenced control unit: state codes,
// jump condition codes and default register-index assignments.
package control_seq_pkg;

  typedef enum logic [1:0] {
    RST   = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam logic [1:0] COND_ALWAYS = 2'd0;
  localparam logic [1:0] COND_ZERO   = 2'd1;
  localparam logic [1:0] COND_CARRY  = 2'd2;
  localparam logic [1:0] COND_SHIFT  = 2'd3;

  localparam int MEM_IDX_DEF = 5;
  localparam int A_IDX_DEF   = 2;
  localparam int PC_IDX_DEF  = 1;

  // Condition code is {c1, c0} of the jump instruction.
  function automatic logic cond_true(logic [1:0] cc, logic z, logic c, logic s);
    logic r;
    case (cc)
      COND_ALWAYS: r = 1'b1;
      COND_ZERO:   r = z;
      COND_CARRY:  r = c;
      default:     r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/control_seq_if.sv
// Bus between the control sequencer (master) and ROM/RAM, register file,
// ALU and PC (slave).
interface control_seq_if #(
  parameter int DEST_W = 3,
  parameter int SRC_W  = 3,
  parameter int IR_W   = DEST_W + SRC_W + 2
);
  logic [IR_W-1:0]        ir;
  logic                   memReady;
  logic                   aIsZero;
  logic                   flagCarry;
  logic                   flagShift;
  logic                   loadBarIR;
  logic [2**DEST_W-1:0]   loadBar;
  logic [2**SRC_W-1:0]    assertBar;
  logic                   assertRom;
  logic                   doSubtract;
  logic                   doCarryIn;
  logic                   doJumpBar;
  logic                   pcInc;
  logic                   zReg;
  logic                   cReg;
  logic                   sReg;
  logic                   halted;

  modport master (
    input  ir, memReady, aIsZero, flagCarry, flagShift,
    output loadBarIR, loadBar, assertBar, assertRom, doSubtract, doCarryIn,
           doJumpBar, pcInc, zReg, cReg, sReg, halted
  );

  modport slave (
    output ir, memReady, aIsZero, flagCarry, flagShift,
    input  loadBarIR, loadBar, assertBar, assertRom, doSubtract, doCarryIn,
           doJumpBar, pcInc, zReg, cReg, sReg, halted
  );
endinterface

// File: rtl/control_seq_demux.sv
// N-to-2**N active-low decoder with enable; all outputs high when disabled.
module control_seq_demux #(
  parameter int N = 3
) (
  input  logic [N-1:0]    sel,
  input  logic            en,
  output logic [2**N-1:0] out_bar
);
  for (genvar i = 0; i < 2**N; i++) begin : g_bit
    assign out_bar[i] = !(en && (sel == N'(i)));
  end
endmodule

// File: rtl/control_seq.sv
// FETCH/EXEC control sequencer with latched IR, registered ALU flags and RAM stall.
// Optional macro CONTROL_SEQ_HALT_EN: all-ones dest+src encoding enters HALT.
module control_seq
  import control_seq_pkg::*;
#(
  parameter int DEST_W  = 3,
  parameter int SRC_W   = 3,
  parameter int IR_W    = DEST_W + SRC_W + 2,
  parameter int MEM_IDX = MEM_IDX_DEF,
  parameter int A_IDX   = A_IDX_DEF,
  parameter int PC_IDX  = PC_IDX_DEF
) (
  input logic            clk,
  input logic            resetBar,
  control_seq_if.master  bus
);
  localparam logic [1:0] ST_RST   = RST;
  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_EXEC  = EXEC;
  localparam logic [1:0] ST_HALT  = HALT;

  logic [1:0]        state;
  logic [IR_W-1:0]   ir_q;
  logic              z_q, c_q, s_q;

  logic              c1, c0;
  logic [DEST_W-1:0] dest;
  logic [SRC_W-1:0]  src;
  assign {c1, dest, c0, src} = ir_q;

  logic is_fetch, is_exec, mem_acc, stall, halt_op, go, take, src_rom;
  assign is_fetch = (state == ST_FETCH);
  assign is_exec  = (state == ST_EXEC);
  assign mem_acc  = (dest == DEST_W'(MEM_IDX)) || (src == SRC_W'(MEM_IDX));
  assign stall    = is_exec && mem_acc && !bus.memReady;
  assign src_rom  = (src == '0);

`ifdef CONTROL_SEQ_HALT_EN
  assign halt_op = (&dest) && (&src);
`else
  assign halt_op = 1'b0;
`endif

  // go marks an EXEC cycle that completes: strobes fire and the edge commits.
  assign go   = is_exec && !stall && !halt_op;
  assign take = go && (dest == DEST_W'(PC_IDX)) && cond_true({c1, c0}, z_q, c_q, s_q);

  logic [2**DEST_W-1:0] load_bar;
  logic [2**SRC_W-1:0]  assert_bar;

  control_seq_demux #(.N(DEST_W)) u_dest_dmx (.sel(dest), .en(go), .out_bar(load_bar));
  control_seq_demux #(.N(SRC_W))  u_src_dmx  (.sel(src),  .en(go), .out_bar(assert_bar));

  assign bus.loadBar    = load_bar;
  assign bus.assertBar  = assert_bar;
  assign bus.loadBarIR  = !is_fetch;
  assign bus.assertRom  = is_fetch || (go && src_rom);
  assign bus.doSubtract = c0;
  assign bus.doCarryIn  = c1;
  assign bus.doJumpBar  = !take;
  // A taken jump reloads the PC, so the immediate increment is suppressed.
  assign bus.pcInc      = is_fetch || (go && src_rom && !take);
  assign bus.zReg       = z_q;
  assign bus.cReg       = c_q;
  assign bus.sReg       = s_q;
`ifdef CONTROL_SEQ_HALT_EN
  assign bus.halted     = (state == ST_HALT);
`else
  assign bus.halted     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetBar) begin
      state <= ST_RST;
      ir_q  <= '0;
      z_q   <= 1'b0;
      c_q   <= 1'b0;
      s_q   <= 1'b0;
    end else begin
      case (state)
        ST_RST:   state <= ST_FETCH;
        ST_FETCH: begin
          ir_q  <= bus.ir;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (halt_op)     state <= ST_HALT;
          else if (!stall) state <= ST_FETCH;
        end
        default:  state <= ST_HALT;
      endcase
      if (go && (dest == DEST_W'(A_IDX))) begin
        z_q <= bus.aIsZero;
        c_q <= bus.flagCarry;
        s_q <= bus.flagShift;
      end
    end
  end

endmodule

// File: tb/tb_control_seq.sv
// Directed vector bench for control_seq: a per-cycle table plus a hand-written
// dest==RAM stall sequence.
module tb_control_seq;
  logic clk = 1'b0;
  logic resetBar;
  always #5 clk = ~clk;

  control_seq_if #(.DEST_W(3), .SRC_W(3)) bus ();

  control_seq dut (.clk(clk), .resetBar(resetBar), .bus(bus));

  typedef struct packed {
    logic        rst_n;
    logic [7:0]  ir;
    logic        mr, az, fc, fs;
    logic [25:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // {loadBarIR, loadBar, assertBar, assertRom, doSubtract, doCarryIn,
  //  doJumpBar, pcInc, {zReg,cReg,sReg}, halted}
  function automatic logic [25:0] o(logic lir, logic [7:0] lb, logic [7:0] ab,
                                    logic rom, logic sub, logic cin, logic jb,
                                    logic inc, logic [2:0] f, logic h);
    return {lir, lb, ab, rom, sub, cin, jb, inc, f, h};
  endfunction

  function automatic logic [25:0] act();
    return {bus.loadBarIR, bus.loadBar, bus.assertBar, bus.assertRom, bus.doSubtract,
            bus.doCarryIn, bus.doJumpBar, bus.pcInc, bus.zReg, bus.cReg, bus.sReg,
            bus.halted};
  endfunction

  task automatic add(logic r, logic [7:0] ir, logic mr, logic az, logic fc, logic fs,
                     logic [25:0] e);
    vec_t v;
    v.rst_n = r; v.ir = ir; v.mr = mr; v.az = az; v.fc = fc; v.fs = fs; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(string name, logic [25:0] a, logic [25:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic chk8(string name, logic [7:0] a, logic [7:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic drive(logic r, logic [7:0] ir, logic mr, logic az, logic fc, logic fs);
    resetBar = r; bus.ir = ir; bus.memReady = mr;
    bus.aIsZero = az; bus.flagCarry = fc; bus.flagShift = fs;
  endtask

  initial begin
    logic [25:0] rsto;
    rsto = o(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 3'b000, 0);

    add(0, 8'h00, 0, 0, 0, 0, rsto);
    add(1, 8'h00, 0, 0, 0, 0, rsto);
    // A <- ROM with aIsZero=1, then jump-if-zero
    add(1, 8'h20, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 0, 1, 1, 3'b000, 0));
    add(1, 8'h00, 0, 1, 0, 0, o(1, 8'hFB, 8'hFE, 1, 0, 0, 1, 1, 3'b000, 0));
    add(1, 8'h18, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 0, 1, 1, 3'b100, 0));
    add(1, 8'h00, 0, 0, 0, 0, o(1, 8'hFD, 8'hFE, 1, 1, 0, 0, 0, 3'b100, 0));
    // A load with carry set, zero clear; jump-if-zero untaken
    add(1, 8'h20, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 1, 0, 1, 1, 3'b100, 0));
    add(1, 8'h00, 0, 0, 1, 0, o(1, 8'hFB, 8'hFE, 1, 0, 0, 1, 1, 3'b100, 0));
    add(1, 8'h18, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 0, 1, 1, 3'b010, 0));
    add(1, 8'h00, 0, 0, 0, 0, o(1, 8'hFD, 8'hFE, 1, 1, 0, 1, 1, 3'b010, 0));
    // jump-if-carry taken
    add(1, 8'h90, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 1, 0, 1, 1, 3'b010, 0));
    add(1, 8'h00, 0, 0, 0, 0, o(1, 8'hFD, 8'hFE, 1, 0, 1, 0, 0, 3'b010, 0));
    // A load with shift only; jump-if-shift taken, jump-if-carry untaken
    add(1, 8'h20, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 1, 1, 1, 3'b010, 0));
    add(1, 8'h00, 0, 0, 0, 1, o(1, 8'hFB, 8'hFE, 1, 0, 0, 1, 1, 3'b010, 0));
    add(1, 8'h98, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 0, 1, 1, 3'b001, 0));
    add(1, 8'h00, 0, 0, 0, 0, o(1, 8'hFD, 8'hFE, 1, 1, 1, 0, 0, 3'b001, 0));
    add(1, 8'h90, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 1, 1, 1, 1, 3'b001, 0));
    add(1, 8'h00, 0, 0, 0, 0, o(1, 8'hFD, 8'hFE, 1, 0, 1, 1, 1, 3'b001, 0));
    // A <- RAM, three stall cycles; ALU inputs during stall must not be captured
    add(1, 8'h25, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 1, 1, 1, 3'b001, 0));
    for (int k = 0; k < 3; k++)
      add(1, 8'h00, 0, 1, 1, 0, o(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 3'b001, 0));
    add(1, 8'h00, 1, 0, 1, 1, o(1, 8'hFB, 8'hDF, 0, 0, 0, 1, 0, 3'b001, 0));
    // reset during a stalled EXEC
    add(1, 8'h25, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 0, 1, 1, 3'b011, 0));
    add(1, 8'h00, 0, 1, 0, 0, o(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 3'b011, 0));
    add(0, 8'h00, 0, 1, 0, 0, o(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 3'b011, 0));
    add(1, 8'h00, 0, 0, 0, 0, rsto);
    // all-ones dest/src encoding
    add(1, 8'h77, 0, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 0, 1, 1, 3'b000, 0));
`ifdef CONTROL_SEQ_HALT_EN
    add(1, 8'h00, 1, 0, 0, 0, o(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 3'b000, 0));
    add(1, 8'h00, 1, 0, 0, 0, o(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 3'b000, 1));
    add(1, 8'h00, 1, 0, 0, 0, o(1, 8'hFF, 8'hFF, 0, 0, 0, 1, 0, 3'b000, 1));
`else
    add(1, 8'h00, 1, 0, 0, 0, o(1, 8'h7F, 8'h7F, 0, 0, 0, 1, 0, 3'b000, 0));
    add(1, 8'h00, 1, 0, 0, 0, o(0, 8'hFF, 8'hFF, 1, 0, 0, 1, 1, 3'b000, 0));
    add(1, 8'h00, 1, 0, 0, 0, o(1, 8'hFE, 8'hFE, 1, 0, 0, 1, 1, 3'b000, 0));
`endif

    drive(0, 8'h00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst_n, tbl[i].ir, tbl[i].mr, tbl[i].az, tbl[i].fc, tbl[i].fs);
      #1;
      chk($sformatf("vec%0d", i), act(), tbl[i].exp);
    end

    // dest==RAM store (RAM <- reg2) with a four-cycle stall
    @(negedge clk); drive(0, 8'h00, 0, 0, 0, 0);
    @(negedge clk); drive(1, 8'h00, 0, 0, 0, 0);
    @(negedge clk); drive(1, 8'h52, 0, 0, 0, 0);
    #1; chk8("st_fetch_lir", {7'd0, bus.loadBarIR}, 8'h00);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); drive(1, 8'h00, 0, 0, 0, 0);
      #1; chk8($sformatf("st_stall%0d", k), bus.loadBar, 8'hFF);
    end
    @(negedge clk); drive(1, 8'h00, 1, 0, 0, 0);
    #1;
    chk8("st_done_load", bus.loadBar, 8'hDF);
    chk8("st_done_assert", bus.assertBar, 8'hFB);
    @(negedge clk);
    #1; chk8("st_refetch_lir", {7'd0, bus.loadBarIR}, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
